// File: rtl/fp_convert_unit.sv
// Iterative IEEE-754 single-precision <-> 32-bit integer converter.
// One shift per cycle, start/busy/done handshake, truncating, {N,Z,C,V} flags.
module fp_convert_unit #(
  parameter bit INT_SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  logic        load_res_s;
  logic [31:0] res_val_s;
  logic        res_c_s;
  logic        res_v_s;
  logic        in_sign_s;
  logic [31:0] in_abs_s;
  logic        f_s;
  logic [7:0]  f_e;
  logic [22:0] f_f;
  logic        f_ovf_s;
  logic [7:0]  shift_amt_s;

  assign f_s = a[31];
  assign f_e = a[30:23];
  assign f_f = a[22:0];
  assign in_sign_s   = INT_SIGNED ? a[31] : 1'b0;
  assign in_abs_s    = in_sign_s ? (~a + 32'd1) : a;
  assign shift_amt_s = 8'd158 - f_e;

  // Infinity always overflows; signed range allows exactly -2^31 at e==158.
  always_comb begin
    f_ovf_s = 1'b0;
    if (f_e == 8'd255) begin
      f_ovf_s = 1'b1;
    end else if (INT_SIGNED) begin
      f_ovf_s = (f_e > 8'd158) || ((f_e == 8'd158) && !(f_s && (f_f == 23'd0)));
    end else begin
      f_ovf_s = (f_e > 8'd158);
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_d     = sign_q;
    sticky_d   = sticky_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    load_res_s = 1'b0;
    res_val_s  = 32'd0;
    res_c_s    = 1'b0;
    res_v_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          sticky_d = 1'b0;
          if (!op) begin
            if (a == 32'd0) begin
              load_res_s = 1'b1;
              state_d    = DONE;
            end else begin
              sign_d  = in_sign_s;
              mag_d   = in_abs_s;
              exp_d   = 8'd158;
              state_d = NORM;
            end
          end else begin
            sign_d = f_s;
            if ((f_e == 8'd255) && (f_f != 23'd0)) begin
              load_res_s = 1'b1;
              res_val_s  = INT_SIGNED ? 32'h8000_0000 : 32'h0000_0000;
              res_v_s    = 1'b1;
              state_d    = DONE;
            end else if (f_ovf_s) begin
              load_res_s = 1'b1;
              res_val_s  = !INT_SIGNED ? 32'hFFFF_FFFF :
                           (f_s ? 32'h8000_0000 : 32'h7FFF_FFFF);
              res_v_s    = 1'b1;
              state_d    = DONE;
            end else if (!INT_SIGNED && f_s && (a != 32'h8000_0000)) begin
              load_res_s = 1'b1;
              res_v_s    = 1'b1;
              state_d    = DONE;
            end else if (f_e < 8'd127) begin
              load_res_s = 1'b1;
              res_c_s    = !((f_e == 8'd0) && (f_f == 23'd0));
              state_d    = DONE;
            end else begin
              mag_d   = {1'b1, f_f, 8'd0};
              cnt_d   = shift_amt_s[4:0];
              state_d = NORM;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (!op_q) begin
          if (!mag_q[31]) begin
            mag_d = {mag_q[30:0], 1'b0};
            exp_d = exp_q - 8'd1;
          end else begin
            load_res_s = 1'b1;
            res_val_s  = {sign_q, exp_q, mag_q[30:8]};
            res_c_s    = |mag_q[7:0];
            state_d    = DONE;
          end
        end else begin
          if (cnt_q != 5'd0) begin
            mag_d    = {1'b0, mag_q[31:1]};
            sticky_d = sticky_q | mag_q[0];
            cnt_d    = cnt_q - 5'd1;
          end else begin
            load_res_s = 1'b1;
            res_val_s  = sign_q ? (~mag_q + 32'd1) : mag_q;
            res_c_s    = sticky_q;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    if (load_res_s) begin
      result_d = res_val_s;
      flags_d  = {res_val_s[31], (res_val_s == 32'd0), res_c_s, res_v_s};
    end else begin
      result_d = result_q;
      flags_d  = flags_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      mag_q    <= 32'd0;
      exp_q    <= 8'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_convert_unit.sv
// Directed bench for fp_convert_unit: latency, result and flags against
// hand-computed vectors, plus busy-start and asynchronous reset behaviour.
module tb_fp_convert_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks;
  int failures;
  int lat;

  fp_convert_unit #(.INT_SIGNED(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // Waits for done after the accepting edge; lat counts cycles from the start cycle.
  task automatic wait_done(input string tag);
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic launch(input logic op_v, input logic [31:0] a_v);
    @(negedge clk);
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    op    = ~op_v;
    lat   = 1;
  endtask

  task automatic run(input string tag, input logic op_v, input logic [31:0] a_v,
                     input int exp_lat, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    launch(op_v, a_v);
    wait_done(tag);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flags});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lat      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    a        = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // int -> float
    run("i2f_one",     1'b0, 32'h0000_0001, 33, 32'h3F80_0000, 4'b0000);
    run("i2f_m1",      1'b0, 32'hFFFF_FFFF, 33, 32'hBF80_0000, 4'b1000);
    run("i2f_maxpos",  1'b0, 32'h7FFF_FFFF, 3,  32'h4EFF_FFFF, 4'b0010);
    run("i2f_zero",    1'b0, 32'h0000_0000, 1,  32'h0000_0000, 4'b0100);
    run("i2f_minneg",  1'b0, 32'h8000_0000, 2,  32'hCF00_0000, 4'b1000);
    run("i2f_inexact", 1'b0, 32'h0100_0001, 9,  32'h4B80_0000, 4'b0010);

    // float -> int
    run("f2i_2p5",     1'b1, 32'h4020_0000, 32, 32'h0000_0002, 4'b0010);
    run("f2i_m3",      1'b1, 32'hC040_0000, 32, 32'hFFFF_FFFD, 4'b1000);
    run("f2i_m2p31",   1'b1, 32'hCF00_0000, 2,  32'h8000_0000, 4'b1000);
    run("f2i_one",     1'b1, 32'h3F80_0000, 33, 32'h0000_0001, 4'b0000);
    run("f2i_exact",   1'b1, 32'h4B00_0001, 10, 32'h0080_0001, 4'b0000);
    run("f2i_pinf",    1'b1, 32'h7F80_0000, 1,  32'h7FFF_FFFF, 4'b0001);
    run("f2i_ninf",    1'b1, 32'hFF80_0000, 1,  32'h8000_0000, 4'b1001);
    run("f2i_nan",     1'b1, 32'h7FC0_0000, 1,  32'h8000_0000, 4'b1001);
    run("f2i_p2p31",   1'b1, 32'h4F00_0000, 1,  32'h7FFF_FFFF, 4'b0001);
    run("f2i_quarter", 1'b1, 32'h3E80_0000, 1,  32'h0000_0000, 4'b0110);
    run("f2i_pzero",   1'b1, 32'h0000_0000, 1,  32'h0000_0000, 4'b0100);
    run("f2i_nzero",   1'b1, 32'h8000_0000, 1,  32'h0000_0000, 4'b0100);

    // start while busy is ignored
    launch(1'b0, 32'h0000_0001);
    repeat (4) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1;
    op    = 1'b1;
    a     = 32'h7F80_0000;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    check("busy_ign_busy", {31'd0, busy}, 32'd1);
    check("busy_ign_nodone", {31'd0, done}, 32'd0);
    wait_done("busy_ign");
    check("busy_ign_lat", lat, 33);
    check("busy_ign_res", result, 32'h3F80_0000);
    check("busy_ign_flags", {28'd0, flags}, 32'd0);
    @(posedge clk); #1;
    check("busy_ign_idle", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-conversion
    launch(1'b1, 32'h4020_0000);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("post_rst_m3", 1'b1, 32'hC040_0000, 32, 32'hFFFF_FFFD, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
